// File: rtl/rsa_modexp.sv
// Modular exponentiation engine (result = base^exp mod mod): left-to-right square-and-multiply
// over a bit-serial interleaved (Blakley) modular multiplier, with optional octet-string I/O.
module rsa_modexp #(
    parameter int WIDTH     = 256,
    parameter int EXP_WIDTH = WIDTH,
    parameter int OCTET_IO  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     mod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic                 busy
);
    localparam int CW = $clog2(EXP_WIDTH + 1);
    localparam int MW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [MW-1:0] MLAST = MW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_SQR, S_MUL, S_DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     base_q, mod_q, r_q, ma_q, acc_q, result_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [CW-1:0]        ecnt_q;
    logic [MW-1:0]        mcnt_q;
    logic                 out_valid_q, err_q;

    logic [WIDTH-1:0]     base_int, r_oct, mb, prod;
    logic [WIDTH+1:0]     p_dbl, p_sub1, p_sub2, mod_ext;

    // Octet 0 (bits [7:0]) is the most significant byte of the integer.
    generate
        if (OCTET_IO != 0) begin : g_oct
            for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_byte
                assign base_int[8*gi +: 8] = base[8*(WIDTH/8-1-gi) +: 8];
                assign r_oct[8*gi +: 8]    = r_q[8*(WIDTH/8-1-gi) +: 8];
            end
        end else begin : g_int
            assign base_int = base;
            assign r_oct    = r_q;
        end
    endgenerate

    // One Blakley step: P = 2P + a_i*b, then at most two subtractions since 2P+b < 3*mod.
    always_comb begin
        mb      = (state_q == S_MUL) ? base_q : r_q;
        mod_ext = {2'b00, mod_q};
        p_dbl   = {1'b0, acc_q, 1'b0} + (ma_q[WIDTH-1] ? {2'b00, mb} : '0);
        p_sub1  = (p_dbl >= mod_ext) ? p_dbl - mod_ext : p_dbl;
        p_sub2  = (p_sub1 >= mod_ext) ? p_sub1 - mod_ext : p_sub1;
        prod    = WIDTH'(p_sub2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            mod_q       <= '0;
            exp_q       <= '0;
            r_q         <= '0;
            ma_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            ecnt_q      <= '0;
            mcnt_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        base_q  <= base_int;
                        exp_q   <= exp;
                        mod_q   <= mod;
                        ecnt_q  <= CW'(EXP_WIDTH);
                        err_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mod_q == '0 || base_q >= mod_q) begin
                        r_q     <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    exp_q  <= exp_q << 1;
                    ecnt_q <= ecnt_q - CW'(1);
                    if (exp_q[EXP_WIDTH-1]) begin
                        r_q     <= base_q;
                        ma_q    <= base_q;
                        acc_q   <= '0;
                        mcnt_q  <= '0;
                        state_q <= (ecnt_q == CW'(1)) ? S_DONE : S_SQR;
                    end else if (ecnt_q == CW'(1)) begin
                        r_q     <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_q <= S_DONE;
                    end
                end
                S_SQR, S_MUL: begin
                    if (mcnt_q != MLAST) begin
                        acc_q  <= prod;
                        ma_q   <= ma_q << 1;
                        mcnt_q <= mcnt_q + MW'(1);
                    end else begin
                        // The product becomes both R and the next multiplier operand.
                        r_q    <= prod;
                        ma_q   <= prod;
                        acc_q  <= '0;
                        mcnt_q <= '0;
                        if (state_q == S_SQR && exp_q[EXP_WIDTH-1]) begin
                            state_q <= S_MUL;
                        end else begin
                            exp_q   <= exp_q << 1;
                            ecnt_q  <= ecnt_q - CW'(1);
                            state_q <= (ecnt_q == CW'(1)) ? S_DONE : S_SQR;
                        end
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        result_q    <= r_oct;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule
